// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Types and helpers shared by the I2S/TDM clock generator.
//   i2s_mode_e     : frame clock style (I2S 50 % LR, or TDM one-bit frame sync)
//   i2s_cfg_t      : one complete clock configuration. Fields are held at the
//                    widest supported width; narrower module ports are
//                    zero-extended into them.
//   i2s_cfg_valid  : returns 1 when a configuration can be applied safely
// -----------------------------------------------------------------------------
package i2s_pkg;

  // Upper bounds for the module width parameters (DIV_W, BITS_W, SLOTS_W).
  localparam int I2S_DIV_MAX_W   = 16;
  localparam int I2S_BITS_MAX_W  = 8;
  localparam int I2S_SLOTS_MAX_W = 8;

  typedef enum logic {
    I2S_MODE_I2S = 1'b0,
    I2S_MODE_TDM = 1'b1
  } i2s_mode_e;

  typedef struct packed {
    logic [I2S_DIV_MAX_W-1:0]   div;
    logic [I2S_BITS_MAX_W-1:0]  slot_bits;
    logic [I2S_SLOTS_MAX_W-1:0] num_slots;
    i2s_mode_e                  mode;
  } i2s_cfg_t;

  // The divider must be even so sclk has a 50 % duty cycle. I2S needs an even
  // slot count so lrck splits the frame into two equal halves.
  function automatic logic i2s_cfg_valid(input i2s_cfg_t c);
    logic bad;
    bad = c.div[0]
       || (c.div < I2S_DIV_MAX_W'(2))
       || (c.slot_bits == '0)
       || (c.num_slots == '0)
       || ((c.mode == I2S_MODE_I2S) && c.num_slots[0]);
    return !bad;
  endfunction

endpackage

// File: rtl/i2s_cfg_shadow.sv
// -----------------------------------------------------------------------------
// i2s_cfg_shadow
// Run-time configuration front end for i2s_clk_gen. It accepts a configuration
// over a valid/ready handshake and validates it. A valid configuration is
// parked in a shadow register, and the shadow is promoted to the active
// configuration only at a frame boundary or while the generator is stopped.
// Only built when I2S_CLK_GEN_RUNTIME_CFG_EN is defined.
//
// Ports
//   i_mclk, i_srst : clock, synchronous active-high reset
//   i_en           : generator run enable (low = apply pending config at once)
//   i_frame_last   : last mclk cycle of the current frame
//   i_cfg_valid    : configuration offered
//   i_cfg          : offered configuration
//   o_cfg_ready    : high while no update is pending
//   o_cfg_err      : one-cycle pulse after an invalid offer was taken
//   o_active       : configuration the counters run on
// -----------------------------------------------------------------------------
module i2s_cfg_shadow
  import i2s_pkg::*;
#(
  parameter i2s_cfg_t DEF_CFG = '0
) (
  input  logic     i_mclk,
  input  logic     i_srst,
  input  logic     i_en,
  input  logic     i_frame_last,
  input  logic     i_cfg_valid,
  input  i2s_cfg_t i_cfg,
  output logic     o_cfg_ready,
  output logic     o_cfg_err,
  output i2s_cfg_t o_active
);

  logic     r_pending;
  logic     r_err;
  i2s_cfg_t r_shadow;
  i2s_cfg_t r_active;

  logic w_xfer;
  logic w_ok;
  logic w_apply;

  assign w_xfer  = i_cfg_valid & ~r_pending;
  assign w_ok    = i2s_cfg_valid(i_cfg);
  // A stopped generator has all counters at 0, so any cycle is a safe boundary.
  assign w_apply = r_pending & (~i_en | i_frame_last);

  always_ff @(posedge i_mclk) begin
    if (i_srst) begin
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_active  <= DEF_CFG;
    end else begin
      // Invalid offers still complete the handshake but never set pending.
      r_err <= w_xfer & ~w_ok;
      if (w_apply) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (w_xfer && w_ok) begin
        r_pending <= 1'b1;
      end
    end
  end

  // NOTE: the shadow is data-only and has no reset; it is only read while
  // r_pending is set, and r_pending itself is reset.
  always_ff @(posedge i_mclk) begin
    if (w_xfer && w_ok) begin
      r_shadow <= i_cfg;
    end
  end

  assign o_cfg_ready = ~r_pending;
  assign o_cfg_err   = r_err;
  assign o_active    = r_active;

endmodule

// File: rtl/i2s_clk_gen.sv
// -----------------------------------------------------------------------------
// i2s_clk_gen
// I2S/TDM bit-clock and frame-clock generator running on mclk. It divides mclk
// into sclk and lrck, and gives mclk-domain strobes and slot/bit indices so
// serialisers can run synchronously on mclk. Frame length is D*B*S mclk cycles.
//
// Build option: with I2S_CLK_GEN_RUNTIME_CFG_EN defined, D/B/S/mode can be
// reprogrammed through the cfg_* handshake (applied on frame boundaries).
// Without it, the configuration is fixed to DEF_*, cfg_ready and cfg_err are
// tied 0, and the cfg_* inputs are ignored.
//
// Ports
//   mclk, srst        : master clock, synchronous active-high reset
//   en                : run enable; low holds counters and outputs at 0
//   cfg_valid/ready   : configuration handshake
//   cfg_sclk_div      : requested mclk/sclk ratio (even, >= 2)
//   cfg_slot_bits     : requested sclk periods per slot (> 0)
//   cfg_num_slots     : requested slots per frame (> 0, even in I2S)
//   cfg_mode          : 0 = I2S, 1 = TDM
//   cfg_err           : one-cycle pulse when an offer is rejected
//   sclk, lrck        : bit clock, frame clock / frame sync
//   sclk_fall_stb     : first mclk of each sclk period (low phase)
//   sclk_rise_stb     : first mclk of each sclk high phase
//   frame_stb         : sclk_fall_stb of bit 0, slot 0
//   bit_idx, slot_idx : current bit in slot, current slot in frame
// -----------------------------------------------------------------------------
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int DIV_W         = 11,
  parameter int BITS_W        = 6,
  parameter int SLOTS_W       = 4,
  parameter int DEF_SCLK_DIV  = 4,
  parameter int DEF_SLOT_BITS = 32,
  parameter int DEF_NUM_SLOTS = 2,
  parameter int DEF_MODE      = 0
) (
  input  logic               mclk,
  input  logic               srst,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_sclk_div,
  input  logic [BITS_W-1:0]  cfg_slot_bits,
  input  logic [SLOTS_W-1:0] cfg_num_slots,
  input  logic               cfg_mode,
  output logic               cfg_err,
  output logic               sclk,
  output logic               lrck,
  output logic               sclk_fall_stb,
  output logic               sclk_rise_stb,
  output logic               frame_stb,
  output logic [BITS_W-1:0]  bit_idx,
  output logic [SLOTS_W-1:0] slot_idx
);

  localparam i2s_cfg_t LP_DEF_CFG = '{
    div:       I2S_DIV_MAX_W'(DEF_SCLK_DIV),
    slot_bits: I2S_BITS_MAX_W'(DEF_SLOT_BITS),
    num_slots: I2S_SLOTS_MAX_W'(DEF_NUM_SLOTS),
    mode:      (DEF_MODE != 0) ? I2S_MODE_TDM : I2S_MODE_I2S
  };

  logic [DIV_W-1:0]   r_div_cnt;
  logic [BITS_W-1:0]  r_bit_idx;
  logic [SLOTS_W-1:0] r_slot_idx;

  i2s_cfg_t w_cfg;
  logic     w_run;
  logic     w_div_last;
  logic     w_bit_last;
  logic     w_slot_last;
  logic     w_frame_last;

  // Counters widened to the configuration field width so every compare is
  // between equal-width unsigned values.
  logic [I2S_DIV_MAX_W-1:0]   w_div_x;
  logic [I2S_BITS_MAX_W-1:0]  w_bit_x;
  logic [I2S_SLOTS_MAX_W-1:0] w_slot_x;

  assign w_div_x  = I2S_DIV_MAX_W'(r_div_cnt);
  assign w_bit_x  = I2S_BITS_MAX_W'(r_bit_idx);
  assign w_slot_x = I2S_SLOTS_MAX_W'(r_slot_idx);

  assign w_run        = en & ~srst;
  assign w_div_last   = (w_div_x == (w_cfg.div - I2S_DIV_MAX_W'(1)));
  assign w_bit_last   = (w_bit_x == (w_cfg.slot_bits - I2S_BITS_MAX_W'(1)));
  assign w_slot_last  = (w_slot_x == (w_cfg.num_slots - I2S_SLOTS_MAX_W'(1)));
  assign w_frame_last = w_div_last & w_bit_last & w_slot_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of the others.
  always_ff @(posedge mclk) begin
    if (srst || !en) begin
      r_div_cnt  <= '0;
      r_bit_idx  <= '0;
      r_slot_idx <= '0;
    end else if (w_div_last) begin
      r_div_cnt <= '0;
      if (w_bit_last) begin
        r_bit_idx  <= '0;
        r_slot_idx <= w_slot_last ? '0 : r_slot_idx + SLOTS_W'(1);
      end else begin
        r_bit_idx <= r_bit_idx + BITS_W'(1);
      end
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Outputs are decoded straight from the counters so strobes line up with
  // the sclk edge they mark.
  assign sclk          = w_run & (w_div_x >= (w_cfg.div >> 1));
  assign sclk_fall_stb = w_run & (r_div_cnt == '0);
  assign sclk_rise_stb = w_run & (w_div_x == (w_cfg.div >> 1));
  assign frame_stb     = sclk_fall_stb & (r_bit_idx == '0) & (r_slot_idx == '0);
  assign bit_idx       = r_bit_idx;
  assign slot_idx      = r_slot_idx;

  // NOTE: default assignment first so every path assigns lrck (no latch).
  always_comb begin
    lrck = 1'b0;
    if (w_run) begin
      case (w_cfg.mode)
        I2S_MODE_I2S: lrck = (w_slot_x >= (w_cfg.num_slots >> 1));
        I2S_MODE_TDM: lrck = (r_bit_idx == '0) && (r_slot_idx == '0);
        default:      lrck = 1'b0;
      endcase
    end
  end

`ifdef I2S_CLK_GEN_RUNTIME_CFG_EN
  i2s_cfg_t w_req;

  assign w_req = '{
    div:       I2S_DIV_MAX_W'(cfg_sclk_div),
    slot_bits: I2S_BITS_MAX_W'(cfg_slot_bits),
    num_slots: I2S_SLOTS_MAX_W'(cfg_num_slots),
    mode:      i2s_mode_e'(cfg_mode)
  };

  i2s_cfg_shadow #(
    .DEF_CFG (LP_DEF_CFG)
  ) u_cfg_shadow (
    .i_mclk       (mclk),
    .i_srst       (srst),
    .i_en         (en),
    .i_frame_last (w_frame_last),
    .i_cfg_valid  (cfg_valid),
    .i_cfg        (w_req),
    .o_cfg_ready  (cfg_ready),
    .o_cfg_err    (cfg_err),
    .o_active     (w_cfg)
  );
`else
  logic w_unused_cfg;

  assign w_cfg     = LP_DEF_CFG;
  assign cfg_ready = 1'b0;
  assign cfg_err   = 1'b0;
  assign w_unused_cfg = ^{cfg_valid, cfg_sclk_div, cfg_slot_bits,
                          cfg_num_slots, cfg_mode, w_frame_last};
`endif

endmodule

// File: tb/tb_i2s_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_i2s_clk_gen
// Scoreboard bench for i2s_clk_gen. Stimulus pushes the expected shape of each
// upcoming frame into a queue; a monitor measures every complete frame
// (bounded by frame_stb) and pops/compares when one finishes. Handshake,
// enable and reset behaviour are checked directly against hand-derived values.
// -----------------------------------------------------------------------------
module tb_i2s_clk_gen;

  logic        mclk = 1'b0;
  logic        srst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [10:0] cfg_sclk_div;
  logic [5:0]  cfg_slot_bits;
  logic [3:0]  cfg_num_slots;
  logic        cfg_mode;
  logic        cfg_err;
  logic        sclk;
  logic        lrck;
  logic        sclk_fall_stb;
  logic        sclk_rise_stb;
  logic        frame_stb;
  logic [5:0]  bit_idx;
  logic [3:0]  slot_idx;

`ifdef I2S_CLK_GEN_RUNTIME_CFG_EN
  localparam logic RT_CFG = 1'b1;
`else
  localparam logic RT_CFG = 1'b0;
`endif

  typedef struct packed {
    int len;
    int n_fall;
    int n_rise;
    int sclk_hi;
    int lrck_hi;
    int lrck_first;
    int max_bit;
    int max_slot;
  } frame_t;

  // Hand-computed frame shapes.
  // Defaults D=4 B=32 S=2 I2S: 256 cycles, lrck high on the second half.
  localparam frame_t FR_DEF = '{len: 256, n_fall: 64, n_rise: 64, sclk_hi: 128,
                                lrck_hi: 128, lrck_first: 128, max_bit: 31, max_slot: 1};
  // D=8 B=16 S=2 I2S: still 256 cycles, half as many sclk periods.
  localparam frame_t FR_D8  = '{len: 256, n_fall: 32, n_rise: 32, sclk_hi: 128,
                                lrck_hi: 128, lrck_first: 128, max_bit: 15, max_slot: 1};
  // TDM D=2 B=32 S=8: 512 cycles, frame sync high for one sclk = 2 mclk.
  localparam frame_t FR_TDM = '{len: 512, n_fall: 256, n_rise: 256, sclk_hi: 256,
                                lrck_hi: 2, lrck_first: 0, max_bit: 31, max_slot: 7};

  frame_t q_exp[$];
  int     n_checks = 0;
  int     n_errors = 0;

  i2s_clk_gen dut (
    .mclk          (mclk),
    .srst          (srst),
    .en            (en),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_sclk_div  (cfg_sclk_div),
    .cfg_slot_bits (cfg_slot_bits),
    .cfg_num_slots (cfg_num_slots),
    .cfg_mode      (cfg_mode),
    .cfg_err       (cfg_err),
    .sclk          (sclk),
    .lrck          (lrck),
    .sclk_fall_stb (sclk_fall_stb),
    .sclk_rise_stb (sclk_rise_stb),
    .frame_stb     (frame_stb),
    .bit_idx       (bit_idx),
    .slot_idx      (slot_idx)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  task automatic cmp_frame(input frame_t a, input frame_t e);
    check("frame_len",        a.len,        e.len);
    check("frame_n_fall",     a.n_fall,     e.n_fall);
    check("frame_n_rise",     a.n_rise,     e.n_rise);
    check("frame_sclk_hi",    a.sclk_hi,    e.sclk_hi);
    check("frame_lrck_hi",    a.lrck_hi,    e.lrck_hi);
    check("frame_lrck_first", a.lrck_first, e.lrck_first);
    check("frame_max_bit",    a.max_bit,    e.max_bit);
    check("frame_max_slot",   a.max_slot,   e.max_slot);
  endtask

  // Monitor: measure each frame from one frame_stb to the next; an interrupted
  // frame (en low or reset) is abandoned without popping an expectation.
  frame_t m_cur;
  bit     m_active = 1'b0;

  always @(negedge mclk) begin
    if (srst || !en) begin
      m_active = 1'b0;
    end else begin
      if (frame_stb) begin
        if (m_active && q_exp.size() > 0) cmp_frame(m_cur, q_exp.pop_front());
        check("frame_stb_is_fall", sclk_fall_stb, 1'b1);
        check("frame_stb_bit0", bit_idx, 0);
        check("frame_stb_slot0", slot_idx, 0);
        m_cur = '0;
        m_cur.lrck_first = -1;
        m_active = 1'b1;
      end
      if (m_active) begin
        if (lrck && m_cur.lrck_first < 0) m_cur.lrck_first = m_cur.len;
        m_cur.len = m_cur.len + 1;
        if (sclk_fall_stb) m_cur.n_fall = m_cur.n_fall + 1;
        if (sclk_rise_stb) m_cur.n_rise = m_cur.n_rise + 1;
        if (sclk) m_cur.sclk_hi = m_cur.sclk_hi + 1;
        if (lrck) m_cur.lrck_hi = m_cur.lrck_hi + 1;
        if (int'(bit_idx) > m_cur.max_bit) m_cur.max_bit = int'(bit_idx);
        if (int'(slot_idx) > m_cur.max_slot) m_cur.max_slot = int'(slot_idx);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // Wait for the next frame_stb, then return just after the following edge so
  // pushed expectations belong to the frame that just began.
  task automatic sync_frame();
    bit seen = 1'b0;
    @(posedge mclk);
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge mclk);
      if (frame_stb) seen = 1'b1;
    end
    if (!seen) fail_timeout("sync_frame");
    tick(1);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && q_exp.size() != 0; i++) @(negedge mclk);
    if (q_exp.size() != 0) begin
      fail_timeout("scoreboard_drain");
      q_exp.delete();
    end
  endtask

  task automatic offer(input int d, input int b, input int s, input logic m);
    cfg_sclk_div  = 11'(d);
    cfg_slot_bits = 6'(b);
    cfg_num_slots = 4'(s);
    cfg_mode      = m;
    cfg_valid     = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    srst = 1'b1;
    en = 1'b1;
    cfg_valid = 1'b0;
    cfg_sclk_div = '0;
    cfg_slot_bits = '0;
    cfg_num_slots = '0;
    cfg_mode = 1'b0;

    // Reset state.
    tick(3);
    @(negedge mclk);
    check("reset_outputs", {sclk, lrck, sclk_fall_stb, sclk_rise_stb, frame_stb}, 0);
    check("reset_idx", {bit_idx, slot_idx}, 0);
    check("reset_cfg_ready", cfg_ready, RT_CFG);
    check("reset_cfg_err", cfg_err, 1'b0);

    // Release with en high: frame_stb in the first cycle out of reset.
    tick(1);
    srst = 1'b0;
    @(negedge mclk);
    check("release_frame_stb", frame_stb, 1'b1);
    check("release_sclk", sclk, 1'b0);
    check("release_lrck", lrck, 1'b0);
    tick(1);
    q_exp.push_back(FR_DEF);
    q_exp.push_back(FR_DEF);
    drain(4000);

`ifdef I2S_CLK_GEN_RUNTIME_CFG_EN
    // Mid-frame offer of D=8 B=16 S=2: old frame completes, then new timing.
    sync_frame();
    q_exp.push_back(FR_DEF);
    q_exp.push_back(FR_D8);
    q_exp.push_back(FR_D8);
    tick(40);
    offer(8, 16, 2, 1'b0);
    @(negedge mclk);
    check("d8_ready_at_offer", cfg_ready, 1'b1);
    tick(1);
    cfg_valid = 1'b0;
    @(negedge mclk);
    check("d8_ready_pending", cfg_ready, 1'b0);
    check("d8_no_err", cfg_err, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge mclk);
      if (cfg_ready) begin
        seen = 1'b1;
        check("d8_ready_returns_at_new_frame", frame_stb, 1'b1);
      end
    end
    if (!seen) fail_timeout("d8_ready_return");
    drain(4000);

    // TDM D=2 B=32 S=8.
    sync_frame();
    q_exp.push_back(FR_D8);
    q_exp.push_back(FR_TDM);
    q_exp.push_back(FR_TDM);
    tick(20);
    offer(2, 32, 8, 1'b1);
    @(negedge mclk);
    check("tdm_ready_at_offer", cfg_ready, 1'b1);
    tick(1);
    cfg_valid = 1'b0;
    @(negedge mclk);
    check("tdm_ready_pending", cfg_ready, 1'b0);
    drain(4000);

    // Invalid offers: odd divider, then odd slot count in I2S.
    sync_frame();
    q_exp.push_back(FR_TDM);
    q_exp.push_back(FR_TDM);
    tick(10);
    offer(3, 32, 8, 1'b1);
    @(negedge mclk);
    check("odd_d_ready_at_offer", cfg_ready, 1'b1);
    tick(1);
    cfg_valid = 1'b0;
    @(negedge mclk);
    check("odd_d_err_pulse", cfg_err, 1'b1);
    check("odd_d_not_pending", cfg_ready, 1'b1);
    tick(1);
    @(negedge mclk);
    check("odd_d_err_single", cfg_err, 1'b0);
    tick(5);
    offer(4, 32, 3, 1'b0);
    @(negedge mclk);
    check("odd_s_ready_at_offer", cfg_ready, 1'b1);
    tick(1);
    cfg_valid = 1'b0;
    @(negedge mclk);
    check("odd_s_err_pulse", cfg_err, 1'b1);
    check("odd_s_not_pending", cfg_ready, 1'b1);
    tick(1);
    @(negedge mclk);
    check("odd_s_err_single", cfg_err, 1'b0);
    drain(4000);
`endif

    // en low for 10 cycles mid-frame; with run-time config, defaults are
    // offered while stopped and must apply immediately.
    sync_frame();
    tick(30);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef I2S_CLK_GEN_RUNTIME_CFG_EN
      if (i == 2) offer(4, 32, 2, 1'b0);
      else cfg_valid = 1'b0;
`endif
      @(negedge mclk);
      check("en_low_outputs", {sclk, lrck, sclk_fall_stb, sclk_rise_stb, frame_stb}, 0);
      if (i > 0) check("en_low_idx", {bit_idx, slot_idx}, 0);
`ifdef I2S_CLK_GEN_RUNTIME_CFG_EN
      if (i == 3) check("en_low_cfg_pending", cfg_ready, 1'b0);
      if (i == 4) check("en_low_cfg_applied", cfg_ready, 1'b1);
`endif
      tick(1);
    end
    en = 1'b1;
    cfg_valid = 1'b0;
    @(negedge mclk);
    check("en_resume_frame_stb", frame_stb, 1'b1);
    tick(1);
    q_exp.push_back(FR_DEF);
    drain(4000);

    // Reset while an update is pending: defaults and cfg_ready afterwards.
    sync_frame();
    tick(20);
    offer(8, 16, 2, 1'b0);
    @(negedge mclk);
    check("rst_offer_ready", cfg_ready, RT_CFG);
    tick(1);
    cfg_valid = 1'b0;
    @(negedge mclk);
    check("rst_offer_no_err", cfg_err, 1'b0);
`ifdef I2S_CLK_GEN_RUNTIME_CFG_EN
    check("rst_offer_pending", cfg_ready, 1'b0);
`endif
    tick(5);
    srst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      check("mid_reset_outputs", {sclk, lrck, sclk_fall_stb, sclk_rise_stb, frame_stb}, 0);
      if (i > 0) check("mid_reset_idx", {bit_idx, slot_idx}, 0);
      tick(1);
    end
    srst = 1'b0;
    @(negedge mclk);
    check("post_reset_frame_stb", frame_stb, 1'b1);
    check("post_reset_cfg_ready", cfg_ready, RT_CFG);
    check("post_reset_cfg_err", cfg_err, 1'b0);
    tick(1);
    q_exp.push_back(FR_DEF);
    q_exp.push_back(FR_DEF);
    drain(4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
